or16_arbiter: RTL and testbench
===============================

OR16_ARBITER -- requirements
Module: or16_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the OR unit (2..8).
REQ-002 Parameter WIDTH, default 16: operand width, fixed at 16 for the Or16 datapath.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester request; held high with stable operands until granted.
REQ-007 a_in  input  N_REQ*16  packed operand a; requester i occupies bits [16*i+15:16*i].
REQ-008 b_in  input  N_REQ*16  packed operand b, same packing as a_in.
REQ-009 gnt  output  N_REQ  one-hot acceptance pulse; combinational; the operands are consumed in this cycle.
REQ-010 out  output  16  registered result a|b of the accepted request.
REQ-011 out_id  output  clog2(N_REQ)  index of the requester that produced out.
REQ-012 out_valid  output  1  out/out_id hold an unconsumed result.
REQ-013 out_ready  input  1  consumer accepts the result when out_valid && out_ready.

Function
REQ-014 State SHALL be EMPTY (out_valid=0) or FULL (out_valid=1), held in a single-entry result register.
REQ-015 An accept slot SHALL exist in a cycle when (state==EMPTY) || out_ready, and reset is low.
REQ-016 In an accept slot with any req bit high, exactly one gnt bit SHALL go high; otherwise gnt SHALL be 0.
REQ-017 Selection SHALL be round-robin: search starts at index (last+1) mod N_REQ, and the first set req bit wins.
REQ-018 last SHALL update to the granted index on each grant, and SHALL stay unchanged when there is no grant.
REQ-019 On a grant, the next edge SHALL load out = a_in[g] | b_in[g] (bitwise, 16 bits, no carry) and out_id = g, and SHALL set FULL.
REQ-020 Latency SHALL be one cycle from grant to out_valid.
REQ-021 Throughput SHALL be one result per cycle while out_ready=1.
REQ-022 In FULL with out_ready=1 and a grant in the same cycle, the result register SHALL reload and the state SHALL stay FULL (back-to-back).
REQ-023 In FULL with out_ready=1 and no grant, the state SHALL become EMPTY; out and out_id SHALL retain their last values.
REQ-024 In FULL with out_ready=0, out, out_id and out_valid SHALL hold, and gnt SHALL be 0 (backpressure).
REQ-025 A requester deasserting req before it is granted SHALL be tolerated; no grant SHALL be issued to it.
REQ-026 With a single active requester, it SHALL be granted in every accept slot.
REQ-027 With all requesters active continuously, each SHALL be granted exactly once per N_REQ consecutive grants.

Reset
REQ-028 While reset=1, gnt SHALL be 0.
REQ-029 On a reset edge, the block SHALL set out=0, out_id=0, out_valid=0, state=EMPTY and last=N_REQ-1, so requester 0 has first priority.
REQ-030 Reset mid-operation SHALL discard a pending result without a handshake; the requests present are re-arbitrated from requester 0 once reset is low.

Structure
REQ-031 A shared package SHALL hold the WIDTH and N_REQ defaults, the ID width constant and the EMPTY/FULL state encoding.
REQ-032 The datapath SHALL instantiate the existing Or16 as the single sub-module, fed by a 16-bit mux of the granted operands.
REQ-033 Arbitration, the pointer and the result register SHALL live in or16_arbiter.

Verification
REQ-034 After reset, req=0001, a0=0000, b0=FFFF, out_ready=1 -> gnt=0001 in cycle 0; next cycle out=FFFF, out_id=0, out_valid=1.
REQ-035 req=1111 held, out_ready=1, operands AAAA/5555 on all requesters -> gnt sequence 0001, 0010, 0100, 1000, 0001; out=FFFF every cycle; out_id=0,1,2,3,0.
REQ-036 req1 with a=3CC3, b=0FF0, out_ready=0 for 3 cycles after the grant -> out=3FF3, out_id=1 and out_valid=1 held; gnt=0 during stall; the next grant fires in the cycle out_ready returns to 1.
REQ-037 req2 with a=1234, b=9876, then req drops, out_ready=1 -> out=9A76, out_id=2; one cycle later out_valid=0 with out still 9A76.
REQ-038 Reset asserted while FULL with out=FFFF -> next cycle out=0000, out_valid=0; with req=1000 held, the first grant after reset is 1000 and last becomes 3.
REQ-039 req=0000 for 10 cycles after reset -> gnt=0, out_valid=0, out=0000 throughout.

Source files
------------

// File: rtl/or16_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin Or16 arbiter.
package or16_arbiter_pkg;

  localparam int unsigned OrWidth     = 16;
  localparam int unsigned NReqDefault = 4;

  // Requester index width; a single requester still gets a 1-bit id
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IdWidth = id_width(NReqDefault);

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

endpackage

// File: rtl/or16_arbiter_or16.sv
// Or16 datapath: bitwise OR of two 16-bit operands, purely combinational.
module or16_arbiter_or16
  import or16_arbiter_pkg::*;
(
  input  logic [OrWidth-1:0] a,
  input  logic [OrWidth-1:0] b,
  output logic [OrWidth-1:0] out
);

  assign out = a | b;

endmodule

// File: rtl/or16_arbiter.sv
// Round-robin arbiter sharing one Or16 unit among N_REQ requesters, with a
// single-entry valid/ready result register.
module or16_arbiter
  import or16_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = NReqDefault,
  parameter int unsigned WIDTH = OrWidth,
  localparam int unsigned IdW  = id_width(N_REQ)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       out,
  output logic [IdW-1:0]         out_id,
  output logic                   out_valid,
  input  logic                   out_ready
);

  state_e           state_q;
  logic [IdW-1:0]   last_q;
  logic [WIDTH-1:0] out_q;
  logic [IdW-1:0]   out_id_q;

  logic             accept;
  logic             found;
  logic             grant;
  logic [IdW-1:0]   idx;
  logic [IdW-1:0]   sel;

  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] or_res;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = a_in[i*WIDTH +: WIDTH];
    assign b_arr[i] = b_in[i*WIDTH +: WIDTH];
  end

  // Search starts one past the last winner, so the last winner has lowest priority
  always_comb begin
    accept = ~reset & ((state_q == StEmpty) | out_ready);
    found  = 1'b0;
    idx    = '0;
    sel    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IdW'((32'(last_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    grant    = found & accept;
    gnt      = '0;
    gnt[sel] = grant;
  end

  assign a_sel = a_arr[sel];
  assign b_sel = b_arr[sel];

  or16_arbiter_or16 u_or16 (
    .a   (a_sel),
    .b   (b_sel),
    .out (or_res)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StEmpty;
      last_q   <= IdW'(N_REQ - 1);
      out_q    <= '0;
      out_id_q <= '0;
    end else if (grant) begin
      state_q  <= StFull;
      last_q   <= sel;
      out_q    <= or_res;
      out_id_q <= sel;
    end else if ((state_q == StFull) && out_ready) begin
      // Drained with nothing behind it; data stays visible but invalid
      state_q <= StEmpty;
    end
  end

  assign out       = out_q;
  assign out_id    = out_id_q;
  assign out_valid = (state_q == StFull);

endmodule

// File: tb/tb_or16_arbiter.sv
// Self-checking bench for or16_arbiter: round-robin model plus result scoreboard.
module tb_or16_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] data;
    int unsigned  id;
  } result_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N-1:0]     gnt;
  logic [W-1:0]     out;
  logic [1:0]       out_id;
  logic             out_valid;
  logic             out_ready;

  int unsigned total = 0;
  int unsigned bad   = 0;

  result_t     exp_q [$];
  logic        m_full = 1'b0;
  int unsigned m_last = N - 1;

  or16_arbiter #(
    .N_REQ (N),
    .WIDTH (W)
  ) u_dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .out       (out),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ops(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  // Reference model: evaluated at the falling edge, advanced for the coming rising edge
  always @(negedge clock) begin
    logic [N-1:0] exp_gnt;
    int           win;
    result_t      r;
    exp_gnt = '0;
    win     = -1;
    if (!reset && (!m_full || out_ready)) begin
      for (int unsigned k = 1; k <= N; k++) begin
        int unsigned j;
        j = (m_last + k) % N;
        if (win < 0 && req[j]) win = int'(j);
      end
    end
    if (win >= 0) exp_gnt[win] = 1'b1;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("out_valid", 32'(out_valid), 32'(m_full));
    if (reset) begin
      exp_q.delete();
      m_full = 1'b0;
      m_last = N - 1;
    end else begin
      if (m_full) begin
        if (exp_q.size() == 0) begin
          chk("sb_underrun", 32'd1, 32'd0);
        end else begin
          chk("sb_data", 32'(out), 32'(exp_q[0].data));
          chk("sb_id", 32'(out_id), exp_q[0].id);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (win >= 0) begin
        r.data = a_in[win*W +: W] | b_in[win*W +: W];
        r.id   = win;
        exp_q.push_back(r);
        m_last = win;
        m_full = 1'b1;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  initial begin
    logic [N-1:0] seq [5];
    logic [N-1:0] g;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

    reset = 1'b1; req = '0; a_in = '0; b_in = '0; out_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_id", 32'(out_id), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);

    // Single requester straight after reset
    tick();
    req = 4'b0001; set_ops(0, 16'h0000, 16'hFFFF);
    @(negedge clock);
    chk("s1_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    @(negedge clock);
    chk("s1_out", 32'(out), 32'hFFFF);
    chk("s1_id", 32'(out_id), 32'h0);
    chk("s1_valid", 32'(out_valid), 32'h1);

    // All four requesting: rotation from requester 0
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    for (int unsigned i = 0; i < N; i++) set_ops(i, 16'hAAAA, 16'h5555);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rr_gnt", 32'(gnt), 32'(seq[i]));
      if (i > 0) begin
        chk("rr_out", 32'(out), 32'hFFFF);
        chk("rr_id", 32'(out_id), 32'(i - 1));
      end
      tick();
    end
    req = '0;
    tick();

    // Backpressure stall
    req = 4'b0010; set_ops(1, 16'h3CC3, 16'h0FF0);
    @(negedge clock);
    chk("bp_gnt0", 32'(gnt), 32'h2);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_gnt_stall", 32'(gnt), 32'h0);
      chk("bp_out", 32'(out), 32'h3FF3);
      chk("bp_id", 32'(out_id), 32'h1);
      chk("bp_valid", 32'(out_valid), 32'h1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_gnt_resume", 32'(gnt), 32'h2);
    tick();
    req = '0;
    repeat (2) tick();

    // Drain keeps last data visible
    req = 4'b0100; set_ops(2, 16'h1234, 16'h9876);
    tick();
    req = '0;
    @(negedge clock);
    chk("dr_out", 32'(out), 32'h9A76);
    chk("dr_id", 32'(out_id), 32'h2);
    tick();
    @(negedge clock);
    chk("dr_valid", 32'(out_valid), 32'h0);
    chk("dr_hold", 32'(out), 32'h9A76);

    // Reset while full discards the pending result
    tick();
    req = 4'b0001; set_ops(0, 16'h0000, 16'hFFFF); out_ready = 1'b0;
    tick();
    req = 4'b1000; set_ops(3, 16'h00F0, 16'h0F00); reset = 1'b1;
    @(negedge clock);
    chk("mr_gnt_rst", 32'(gnt), 32'h0);
    tick();
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    chk("mr_out", 32'(out), 32'h0);
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_gnt", 32'(gnt), 32'h8);
    tick();
    req = 4'b1111;
    @(negedge clock);
    chk("mr_next", 32'(gnt), 32'h1);
    tick();

    // Idle after reset
    req = '0; reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_out", 32'(out), 32'h0);
      tick();
    end

    // Random traffic: requests held until granted, occasional withdrawal
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      g = gnt;
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      for (int unsigned i = 0; i < N; i++) begin
        if (g[i] || !req[i]) begin
          req[i] = ($urandom_range(0, 2) == 0);
          set_ops(i, 16'($urandom), 16'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0; out_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
